// File: rtl/k2_io_pkg.sv
// k2_io_pkg: shared types and line levels for the K2 processor I/O stages.
//
// Contents:
//   tx_state_t   serial transmitter FSM states (PARITY is only entered when
//                the design is built with R0_UART_PARITY_EN defined)
//   IDLE_LEVEL   level of an idle serial line
//   START_LEVEL  level of a start bit
//   STOP_LEVEL   level of a stop bit
package k2_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy, for the K2 I/O stages.
//
// Parameters:
//   DATA_W  entry width
//   DEPTH   number of entries (power of two, at least 2)
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset (pointers and count only)
//   push   in   write din; ignored while full
//   pop    in   advance the read pointer; ignored while empty
//   din    in   write data
//   dout   out  head entry (valid while !empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  current occupancy, 0..DEPTH
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/r0_uart_tx.sv
// r0_uart_tx: watches the K2 R0 register and sends every new value as a UART
// frame (start, DATA_W bits LSB first, optional even parity, stop).
//
// Build option: define R0_UART_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit (frame = 11*CLKS_PER_BIT instead of 10*).
//
// Parameters:
//   DATA_W        width of R0 and of the payload
//   DEPTH         FIFO entries (power of two, at least 2)
//   CLKS_PER_BIT  clk cycles per serial bit (at least 1)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset; aborts any frame in flight
//   r0        in   R0 value from the processor
//   ovf_clr   in   one-cycle pulse clearing the overflow flag
//   tx        out  serial line, idles high
//   busy      out  a frame is on the line
//   full      out  FIFO holds DEPTH entries
//   count     out  FIFO occupancy
//   overflow  out  sticky: a changed R0 value was dropped
module r0_uart_tx
    import k2_io_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      r0,
    input  logic                   ovf_clr,
    output logic                   tx,
    output logic                   busy,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LOAD = IW'(DATA_W - 1);
`ifdef R0_UART_PARITY_EN
    localparam tx_state_t AFTER_DATA = PARITY;
`else
    localparam tx_state_t AFTER_DATA = STOP;
`endif

    logic [DATA_W-1:0] r0_q;
    logic [DATA_W-1:0] fifo_dout;
    logic [DATA_W-1:0] shreg;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              bit_done;
    tx_state_t         state;
    logic [TW-1:0]     tmr;
    logic [IW-1:0]     idx;
`ifdef R0_UART_PARITY_EN
    logic              par_q;
`endif

    assign push     = (r0 != r0_q);
    assign bit_done = (tmr == '0);
    // The head is taken either from idle or on the last stop-bit cycle, so
    // queued values go out back-to-back with no idle gap.
    assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
    assign busy     = (state != IDLE);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (r0),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .count (count)
    );

    // Change detect and sticky overflow; a drop wins over a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_q     <= '0;
            overflow <= 1'b0;
        end else begin
            r0_q <= r0;
            if (push && full) overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // Frame sequencer: tmr counts each bit down, idx counts data bits down.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tmr   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= START;
                        tmr   <= TMR_LOAD;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state <= DATA;
                        tmr   <= TMR_LOAD;
                        idx   <= IDX_LOAD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        tmr <= TMR_LOAD;
                        if (idx == '0) state <= AFTER_DATA;
                        else           idx   <= idx - 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
`ifdef R0_UART_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        tmr   <= TMR_LOAD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            state <= START;
                            tmr   <= TMR_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload path: loaded on pop, shifted right at the end of each data bit.
    always_ff @(posedge clk) begin
        if (pop) shreg <= fifo_dout;
        else if ((state == DATA) && bit_done) shreg <= shreg >> 1;
    end

`ifdef R0_UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (pop) par_q <= ^fifo_dout;
    end
`endif

    always_comb begin
        tx = IDLE_LEVEL;
        case (state)
            START: tx = START_LEVEL;
            DATA:  tx = shreg[0];
`ifdef R0_UART_PARITY_EN
            PARITY: tx = par_q;
`endif
            STOP:  tx = STOP_LEVEL;
            default: tx = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_r0_uart_tx.sv
// tb_r0_uart_tx: self-checking bench for r0_uart_tx (DEPTH=4, CLKS_PER_BIT=4).
// Honors R0_UART_PARITY_EN: with it defined the parity scenario runs and the
// reference model expects 11-bit frames.
module tb_r0_uart_tx;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef R0_UART_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] r0 = '0;
    logic          ovf_clr = 1'b0;
    logic          tx;
    logic          busy;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;

    r0_uart_tx #(
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .r0       (r0),
        .ovf_clr  (ovf_clr),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Queue of pending bytes; a byte leaves when the line is free, and the line
    // is busy for FRAME cycles after that. tx is derived from the position
    // inside the current frame.
    logic [DW-1:0] mq[$];
    int            cyc = 0;
    int            last_pop = 0;
    bit            lp_valid = 1'b0;
    logic [DW-1:0] last_byte = '0;
    logic [DW-1:0] prev = '0;
    bit            movf = 1'b0;
    bit            armed = 1'b0;
    bit            m_push, m_full, m_pop;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            mq.delete();
            lp_valid = 1'b0;
            prev     = '0;
            movf     = 1'b0;
            armed    = 1'b1;
        end else begin
            m_push = (r0 != prev);
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() != 0) && (!lp_valid || (cyc >= last_pop + FRAME));
            if (m_pop) begin
                last_byte = mq.pop_front();
                last_pop  = cyc;
                lp_valid  = 1'b1;
            end
            if (m_push && m_full) movf = 1'b1;
            else if (ovf_clr)     movf = 1'b0;
            if (m_push && !m_full) mq.push_back(r0);
            prev = r0;
        end
        cyc++;
    end

    function automatic logic [6:0] model_out();
        int   o;
        int   b;
        logic t;
        logic bz;
        t  = 1'b1;
        bz = 1'b0;
        if (lp_valid) begin
            o = cyc - last_pop - 1;
            if (o < FRAME) begin
                bz = 1'b1;
                b  = o / CPB;
                if (b == 0)                        t = 1'b0;
                else if (b <= DW)                  t = last_byte[3'(b - 1)];
                else if (PAR && (b == DW + 1))     t = ^last_byte;
            end
        end
        return {t, bz, (mq.size() == DEPTH), CW'(mq.size()), movf};
    endfunction

    initial forever begin
        @(negedge clk);
        if (armed) check("model{tx,busy,full,count,ovf}", {tx, busy, full, count, overflow}, model_out());
    end

    // ---------------- serial decoder ----------------
    typedef struct {
        logic [DW-1:0] d;
        bit            ok;
    } rx_t;
    rx_t           rx_q[$];
    logic [DW-1:0] rx_d;
    bit            rx_ok;

    initial forever begin
        @(negedge clk);
        if (armed && !reset && tx === 1'b0) begin
            rx_ok = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            if (tx !== 1'b0) rx_ok = 1'b0;
            for (int i = 0; i < DW; i++) begin
                repeat (CPB) @(negedge clk);
                rx_d[3'(i)] = tx;
            end
            if (PAR) begin
                repeat (CPB) @(negedge clk);
                if (tx !== ^rx_d) rx_ok = 1'b0;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) rx_ok = 1'b0;
            rx_q.push_back('{rx_d, rx_ok});
        end
    end

    task automatic do_reset();
        reset   = 1'b1;
        r0      = '0;
        ovf_clr = 1'b0;
        next();
        next();
        reset = 1'b0;
        rx_q.delete();
    endtask

    typedef struct {
        int   first;
        int   last;
        logic tx;
        logic busy;
    } seg_t;

    typedef struct {
        logic [DW-1:0] r0;
        logic          clr;
        logic [CW-1:0] cnt;
        logic          full;
        logic          ovf;
    } vec_t;

    seg_t segs[12];
    vec_t vecs[12];
    logic txv[64];
    logic bv[64];
    int   lows;
    int   w;
    int   nb;
    int   rates[3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------- reset state and idle line ----------
        reset = 1'b1;
        r0    = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_count", count, 0);
        check("reset_overflow", overflow, 0);
        check("reset_full", full, 0);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("idle_tx_low_cycles", lows, 0);
        next();

`ifndef R0_UART_PARITY_EN
        // ---------- single 0x5A frame, cycle-exact ----------
        segs[0]  = '{0, 11, 1'b1, 1'b0};
        segs[1]  = '{12, 15, 1'b0, 1'b1};
        segs[2]  = '{16, 19, 1'b0, 1'b1};
        segs[3]  = '{20, 23, 1'b1, 1'b1};
        segs[4]  = '{24, 27, 1'b0, 1'b1};
        segs[5]  = '{28, 31, 1'b1, 1'b1};
        segs[6]  = '{32, 35, 1'b1, 1'b1};
        segs[7]  = '{36, 39, 1'b0, 1'b1};
        segs[8]  = '{40, 43, 1'b1, 1'b1};
        segs[9]  = '{44, 47, 1'b0, 1'b1};
        segs[10] = '{48, 51, 1'b1, 1'b1};
        segs[11] = '{52, 60, 1'b1, 1'b0};
        for (int c = 0; c <= 60; c++) begin
            r0 = (c >= 10) ? 8'h5A : 8'h00;
            @(negedge clk);
            for (int s = 0; s < 12; s++) begin
                if (c >= segs[s].first && c <= segs[s].last) begin
                    check($sformatf("frame5A_tx_c%0d", c), tx, segs[s].tx);
                    check($sformatf("frame5A_busy_c%0d", c), busy, segs[s].busy);
                end
            end
            if (c == 11) check("frame5A_count_c11", count, 1);
            next();
        end
`endif

        // ---------- burst fill, drop, overflow set/clear ----------
        do_reset();
        vecs[0]  = '{8'h01, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{8'h02, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[2]  = '{8'h03, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[3]  = '{8'h04, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[4]  = '{8'h05, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[5]  = '{8'h06, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[6]  = '{8'h06, 1'b0, 3'd4, 1'b1, 1'b1};
        vecs[7]  = '{8'h06, 1'b1, 3'd4, 1'b1, 1'b1};
        vecs[8]  = '{8'h06, 1'b0, 3'd4, 1'b1, 1'b0};
        vecs[9]  = '{8'h07, 1'b1, 3'd4, 1'b1, 1'b0};
        vecs[10] = '{8'h07, 1'b0, 3'd4, 1'b1, 1'b1};
        vecs[11] = '{8'h07, 1'b0, 3'd4, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            r0      = vecs[i].r0;
            ovf_clr = vecs[i].clr;
            @(negedge clk);
            check($sformatf("burst_count_t%0d", i), count, vecs[i].cnt);
            check($sformatf("burst_full_t%0d", i), full, vecs[i].full);
            check($sformatf("burst_overflow_t%0d", i), overflow, vecs[i].ovf);
            next();
        end
        ovf_clr = 1'b0;
        w = 0;
        while (rx_q.size() < 5 && w < 400) begin
            next();
            w++;
        end
        check("burst_frames_received", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            check($sformatf("burst_frame%0d_data", i), rx_q[i].d, i + 1);
            check($sformatf("burst_frame%0d_framing", i), rx_q[i].ok, 1);
        end

        // ---------- reset in the middle of a 0xFF frame ----------
        do_reset();
        for (int c = 0; c < 32; c++) begin
            r0 = 8'hFF;
            next();
        end
        reset = 1'b1;
        r0    = 8'h00;
        @(negedge clk);
        check("midreset_busy_before", busy, 1);
        next();
        reset = 1'b0;
        @(negedge clk);
        check("midreset_tx", tx, 1);
        check("midreset_count", count, 0);
        check("midreset_busy", busy, 0);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("midreset_no_resume", lows, 0);
        next();

`ifdef R0_UART_PARITY_EN
        // ---------- parity frame for 0x07 ----------
        do_reset();
        for (int c = 0; c < 64; c++) begin
            r0 = 8'h07;
            @(negedge clk);
            txv[c] = tx;
            bv[c]  = busy;
            next();
        end
        check("par_tx_c1", txv[1], 1);
        check("par_start_c2", txv[2], 0);
        check("par_bit7_c35", txv[35], 0);
        check("par_parity_c39", txv[39], 1);
        check("par_stop_c43", txv[43], 1);
        check("par_busy_c45", bv[45], 1);
        check("par_busy_c46", bv[46], 0);
        nb = 0;
        for (int c = 0; c < 64; c++) if (bv[c] === 1'b1) nb++;
        check("par_frame_len", nb, 44);
        check("par_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            check("par_rx_data", rx_q[0].d, 8'h07);
            check("par_rx_framing", rx_q[0].ok, 1);
        end
`endif

        // ---------- randomized traffic against the model ----------
        do_reset();
        rates[0] = 2;
        rates[1] = 16;
        rates[2] = 64;
        for (int blk = 0; blk < 6; blk++) begin
            nb = rates[$urandom_range(0, 2)];
            repeat (500) begin
                if ($urandom_range(0, nb - 1) == 0) r0 = DW'($urandom);
                ovf_clr = ($urandom_range(0, 40) == 0);
                reset   = ($urandom_range(0, 700) == 0);
                next();
            end
        end
        reset   = 1'b0;
        ovf_clr = 1'b0;
        repeat (250) next();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
